// File: rtl/if_fetch_unit_if.sv
// Instruction-memory bus between the fetch stage (master) and imem (slave).
// Request: one transfer per cycle where req_valid && req_ready; response: rsp_valid is a one-cycle, unstallable pulse.
interface if_fetch_unit_if #(
  parameter int IW = 32,
  parameter int AW = 32
);
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [IW-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, 2-entry response queue, redirect/drain.
// Optional delivered-instruction counter enabled by defining IF_FETCH_CNT_EN.
module if_fetch_unit #(
  parameter int            IW       = 32,
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  if_fetch_unit_if.master   imem,
  input  logic              redirect_valid,
  input  logic [AW-1:0]     redirect_pc,
  input  logic              stall,
  output logic [IW-1:0]     instruction_out,
  output logic              instr_valid,
  output logic [AW-1:0]     instr_pc,
  output logic [31:0]       fetch_count,
  output logic              state_dbg
);

  typedef enum logic {FETCH = 1'b0, DRAIN = 1'b1} state_t;

  state_t        state, state_n;
  logic [AW-1:0] pc, pc_n;
  logic [1:0]    os, os_n;
  logic [1:0]    drop, drop_n;
  logic [1:0]    cnt;
  logic [AW-1:0] f_pc  [2];
  logic [IW-1:0] f_ins [2];
  logic          hs, rsp, pop, push, flush;
  logic [AW-1:0] rsp_pc;

  assign imem.imem_req_valid = !rst && (state == FETCH) && !redirect_valid &&
                               (({1'b0, os} + {1'b0, cnt}) < 3'd2);
  assign imem.imem_req_addr  = pc;

  assign hs  = imem.imem_req_valid && imem.imem_req_ready;
  assign rsp = imem.imem_rsp_valid;

  assign instr_valid     = (cnt != 2'd0);
  assign instruction_out = instr_valid ? f_ins[0] : '0;
  assign instr_pc        = instr_valid ? f_pc[0]  : '0;
  assign pop             = instr_valid && !stall;
  assign state_dbg       = (state == DRAIN);

  // In FETCH every outstanding request belongs to the current stream, so the
  // oldest one was issued os words behind the PC.
  assign rsp_pc = pc - {{(AW-4){1'b0}}, os, 2'b00};

  always_comb begin
    state_n = state;
    pc_n    = pc;
    os_n    = os + {1'b0, hs} - {1'b0, rsp};
    drop_n  = drop;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      flush   = 1'b1;
      pc_n    = redirect_pc;
      drop_n  = os_n;
      state_n = (os_n != 2'd0) ? DRAIN : FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (hs) pc_n = pc + AW'(4);
          push = rsp;
        end
        DRAIN: begin
          if (rsp) begin
            drop_n = drop - 2'd1;
            if (drop == 2'd1) state_n = FETCH;
          end
        end
        default: state_n = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
      os    <= 2'd0;
      drop  <= 2'd0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      os    <= os_n;
      drop  <= drop_n;
    end
  end

  // Entry 0 is always the head; entry 1 shifts down on a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 2'd0;
      f_pc[0]  <= '0;
      f_pc[1]  <= '0;
      f_ins[0] <= '0;
      f_ins[1] <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            f_pc[0]  <= rsp_pc;
            f_ins[0] <= imem.imem_rsp_data;
          end else begin
            f_pc[1]  <= rsp_pc;
            f_ins[1] <= imem.imem_rsp_data;
          end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          f_pc[0]  <= f_pc[1];
          f_ins[0] <= f_ins[1];
          cnt      <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            f_pc[0]  <= rsp_pc;
            f_ins[0] <= imem.imem_rsp_data;
          end else begin
            f_pc[0]  <= f_pc[1];
            f_ins[0] <= f_ins[1];
            f_pc[1]  <= rsp_pc;
            f_ins[1] <= imem.imem_rsp_data;
          end
        end
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef IF_FETCH_CNT_EN
  logic [31:0] fetch_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      fetch_cnt_q <= 32'd0;
    else if (pop) fetch_cnt_q <= fetch_cnt_q + 32'd1;
  end
  assign fetch_count = fetch_cnt_q;
`else
  assign fetch_count = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a 1-cycle-minimum imem model whose responses can be held back.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] instruction_out;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic [31:0] fetch_count;
  logic        state_dbg;

  if_fetch_unit_if #(.IW(32), .AW(32)) ifc ();

  if_fetch_unit #(.IW(32), .AW(32), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem            (ifc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .stall           (stall),
    .instruction_out (instruction_out),
    .instr_valid     (instr_valid),
    .instr_pc        (instr_pc),
    .fetch_count     (fetch_count),
    .state_dbg       (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        rsp_en;
  logic [31:0] pend_q[$];
  logic [31:0] cnt10;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'h11;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; imem accepts on the handshake and answers, oldest first,
  // from the next cycle onward whenever rsp_en is high.
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    @(negedge clk);
    hs = ifc.imem_req_valid && ifc.imem_req_ready;
    a  = ifc.imem_req_addr;
    @(posedge clk);
    #1;
    if (hs) pend_q.push_back(a);
    if (rsp_en && pend_q.size() > 0) begin
      ifc.imem_rsp_valid = 1'b1;
      ifc.imem_rsp_data  = mem(pend_q.pop_front());
    end else begin
      ifc.imem_rsp_valid = 1'b0;
      ifc.imem_rsp_data  = 32'h0;
    end
  endtask

  task automatic reset_hold(input logic rdy, input logic ren, input logic stl);
    rst                = 1'b1;
    pend_q.delete();
    ifc.imem_rsp_valid = 1'b0;
    ifc.imem_rsp_data  = 32'h0;
    ifc.imem_req_ready = rdy;
    rsp_en             = ren;
    stall              = stl;
    redirect_valid     = 1'b0;
    redirect_pc        = 32'h0;
    tick();
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, {31'h0, ifc.imem_req_valid}, 32'h0);
    chk({tag, "_req_addr"},  ifc.imem_req_addr, 32'h0);
    chk({tag, "_valid"},     {31'h0, instr_valid}, 32'h0);
    chk({tag, "_instr"},     instruction_out, 32'h0);
    chk({tag, "_pc"},        instr_pc, 32'h0);
    chk({tag, "_count"},     fetch_count, 32'h0);
    chk({tag, "_state"},     {31'h0, state_dbg}, 32'h0);
  endtask

  initial begin
`ifdef IF_FETCH_CNT_EN
    cnt10 = 32'd10;
`else
    cnt10 = 32'd0;
`endif
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    stall = 1'b0;
    rsp_en = 1'b0;
    ifc.imem_req_ready = 1'b0;
    ifc.imem_rsp_valid = 1'b0;
    ifc.imem_rsp_data = 32'h0;

    // Reset release and basic stream (credit rule leaves a bubble every third cycle)
    reset_hold(1'b1, 1'b1, 1'b0);
    chk_reset_outputs("rst");
    rst = 1'b0; #1;
    chk("t1_c0_req_valid", {31'h0, ifc.imem_req_valid}, 32'h1);
    chk("t1_c0_addr", ifc.imem_req_addr, 32'h0);
    tick();
    chk("t1_c1_valid", {31'h0, instr_valid}, 32'h0);
    chk("t1_c1_addr", ifc.imem_req_addr, 32'h4);
    tick();
    chk("t1_c2_valid", {31'h0, instr_valid}, 32'h1);
    chk("t1_c2_pc", instr_pc, 32'h0);
    chk("t1_c2_instr", instruction_out, 32'h11);
    chk("t1_c2_req_valid", {31'h0, ifc.imem_req_valid}, 32'h0);
    tick();
    chk("t1_c3_pc", instr_pc, 32'h4);
    chk("t1_c3_instr", instruction_out, 32'h22);
    chk("t1_c3_addr", ifc.imem_req_addr, 32'h8);
    tick();
    chk("t1_c4_valid", {31'h0, instr_valid}, 32'h0);
    chk("t1_c4_instr", instruction_out, 32'h0);
    tick();
    chk("t1_c5_pc", instr_pc, 32'h8);
    chk("t1_c5_instr", instruction_out, 32'h33);

    // Stall: two credits used, head held, nothing lost afterwards
    reset_hold(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    tick(); tick();
    chk("t2_c2_req_valid", {31'h0, ifc.imem_req_valid}, 32'h0);
    chk("t2_c2_pc", instr_pc, 32'h0);
    tick();
    chk("t2_c3_req_valid", {31'h0, ifc.imem_req_valid}, 32'h0);
    chk("t2_c3_instr", instruction_out, 32'h11);
    tick();
    chk("t2_c4_instr", instruction_out, 32'h11);
    chk("t2_c4_pc", instr_pc, 32'h0);
    tick();
    stall = 1'b0;
    chk("t2_c5_pc", instr_pc, 32'h0);
    tick();
    chk("t2_c6_pc", instr_pc, 32'h4);
    chk("t2_c6_instr", instruction_out, 32'h22);
    chk("t2_c6_addr", ifc.imem_req_addr, 32'h8);
    tick();
    chk("t2_c7_valid", {31'h0, instr_valid}, 32'h0);
    tick();
    chk("t2_c8_pc", instr_pc, 32'h8);
    chk("t2_c8_instr", instruction_out, 32'h33);

    // imem not ready: address holds, bubbles out
    reset_hold(1'b0, 1'b1, 1'b0);
    rst = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t3_c%0d_addr", i), ifc.imem_req_addr, 32'h0);
      chk($sformatf("t3_c%0d_valid", i), {31'h0, instr_valid}, 32'h0);
      chk($sformatf("t3_c%0d_instr", i), instruction_out, 32'h0);
      tick();
    end
    ifc.imem_req_ready = 1'b1;
    tick();
    chk("t3_c4_addr", ifc.imem_req_addr, 32'h4);
    tick();
    chk("t3_c5_pc", instr_pc, 32'h0);
    chk("t3_c5_instr", instruction_out, 32'h11);

    // Redirect with two requests outstanding
    reset_hold(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    tick(); tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    rsp_en = 1'b1;
    #1;
    chk("t4_c2_req_valid", {31'h0, ifc.imem_req_valid}, 32'h0);
    tick();
    redirect_valid = 1'b0;
    chk("t4_c3_state", {31'h0, state_dbg}, 32'h1);
    chk("t4_c3_valid", {31'h0, instr_valid}, 32'h0);
    tick();
    chk("t4_c4_valid", {31'h0, instr_valid}, 32'h0);
    chk("t4_c4_req_valid", {31'h0, ifc.imem_req_valid}, 32'h0);
    tick();
    chk("t4_c5_state", {31'h0, state_dbg}, 32'h0);
    chk("t4_c5_req_valid", {31'h0, ifc.imem_req_valid}, 32'h1);
    chk("t4_c5_addr", ifc.imem_req_addr, 32'h100);
    chk("t4_c5_valid", {31'h0, instr_valid}, 32'h0);
    tick();
    chk("t4_c6_valid", {31'h0, instr_valid}, 32'h0);
    tick();
    chk("t4_c7_valid", {31'h0, instr_valid}, 32'h1);
    chk("t4_c7_pc", instr_pc, 32'h100);
    chk("t4_c7_instr", instruction_out, 32'h451);

    // Redirect in the same cycle a response arrives: one stale word left to drop
    reset_hold(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    rsp_en = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk("t5_c3_state", {31'h0, state_dbg}, 32'h1);
    chk("t5_c3_valid", {31'h0, instr_valid}, 32'h0);
    tick();
    chk("t5_c4_state", {31'h0, state_dbg}, 32'h0);
    chk("t5_c4_valid", {31'h0, instr_valid}, 32'h0);
    chk("t5_c4_addr", ifc.imem_req_addr, 32'h200);
    tick();
    chk("t5_c5_valid", {31'h0, instr_valid}, 32'h0);
    tick();
    chk("t5_c6_pc", instr_pc, 32'h200);
    chk("t5_c6_instr", instruction_out, 32'h891);

    // Ten deliveries, three stalled cycles, then reset mid-run
    reset_hold(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("t6_c15_pc", instr_pc, 32'h24);
    tick();
    stall = 1'b1;
    chk("t6_c16_count", fetch_count, cnt10);
    tick();
    chk("t6_c17_count", fetch_count, cnt10);
    tick();
    chk("t6_c18_count", fetch_count, cnt10);
    chk("t6_c18_valid", {31'h0, instr_valid}, 32'h1);
    rst = 1'b1;
    pend_q.delete();
    ifc.imem_rsp_valid = 1'b0;
    #1;
    chk_reset_outputs("t6_midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
